maf_t5_norm: RTL and testbench
==============================

# maf_t5_norm

Normalization stage directly downstream of the T4_3 register of the multi-precision MAF pipeline, consuming its bundle: product register, shift count, shift enables, revision bits, exponent, signs and mode. It left-shifts each lane by the leading-zero amount plus revision and emits normalized mantissas with guard/sticky bits for the rounding stage. It is a 2-deep valid/ready pipeline (capture stage A, shift stage B), so the rounder can apply backpressure.

## Interface
- No parameters. Widths are fixed by the pipeline: 74-bit product, 12-bit exponent.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage A can accept.
- p_reg  in  74  product from T4_3.
- sh_num  in  10  leading-zero counts; single lane uses [5:0]; dual lanes use [9:5] (high) and [4:0] (low).
- esh  in  2  per-lane shift enable (bit1 high lane, bit0 low/single).
- revi  in  2  per-lane revision, one extra left shift.
- e_in  in  12  exponent, already corrected; passed through.
- s2, s2h  in  1 each  low/high result signs; passed through.
- cont  in  3  mode: cont[1]=1 mode3 single; cont[1:0]=00 mode1 single; cont[1:0]=01 mode2 dual; cont[2] passed through.
- out_valid  out  1  stage B result valid.
- out_ready  in  1  downstream accepts.
- mant_o  out  53  single: {53 normalized}; dual: {5'b0, high 24, low 24}.
- grd_o, stk_o  out  2 each  per-lane guard/sticky ([0] = single/low lane).
- zero_o  out  2  per-lane all-zero after shift.
- nerr_o  out  2  per-lane nonzero result whose MSB is 0.
- e_o, s2_o, s2h_o, cont_o  out  12/1/1/3  passthrough.

## Operation
- Stage A register: captures all inputs when in_valid && in_ready. No arithmetic.
- Stage B computes from stage A contents.
- Single lane (mode1/mode3): amount = (esh[0] ? sh_num[5:0] : 0) + revi[0], range 0..64. Shift = p_reg << amount, 74 bits, MSB side discarded. Mantissa = shifted[73:21], guard = [20], sticky = |[19:0].
- Dual lane (mode2): high = p_reg[73:37], low = p_reg[36:0]. Each lane is shifted independently by (esh[i] ? its 5-bit count : 0) + revi[i], range 0..32. There is no cross-lane bit leakage. Each lane yields mantissa [36:13], guard [12], sticky |[11:0]. In single mode, index [1] of grd/stk/zero/nerr is 0.
- zero_o[i] = 1 when the shifted lane is entirely 0; nerr_o[i] = 1 when the lane is nonzero and the shifted MSB is 0.
- Passthrough fields travel with their bundle unchanged.

## Timing
- Reset: all valids 0, in_ready 1, every data/flag output 0.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput 1 per cycle.
- Handshake:
  - B loads when !out_valid || out_ready.
  - in_ready = !vA || B loads, so simultaneous A→B and input→A transfers occur in the same cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid never drops without out_ready.
- Full pipeline plus out_ready=0: in_ready=0, and no bundle is lost or duplicated.
- Reset mid-operation clears both valids immediately, independent of clk. In-flight bundles are dropped.
- in_valid while in_ready=0: the upstream holds its data. The block does not sample it.

## Configuration
- MAF_NORM_STICKY_EN defined: grd_o and stk_o are computed as above.
- Not defined: grd_o and stk_o are tied 0 and the sticky OR trees are not built. The mantissa and all other outputs are unchanged.

## Test plan
- Mode1: p_reg=74'h1 << 50, sh_num=6'd23, esh=01, revi=00 → after 2 cycles mant_o[52]=1, all other mant bits 0, zero_o=00, nerr_o=00.
- Mode2: high lane 37'h1 << 20, low lane 37'h1 << 30, sh_num={5'd16, 5'd6}, esh=11, revi=00 → both lane mantissas are 24'h800000 and no high-lane bits appear in the low lane.
- Revision: mode1, same value as test 1 but sh_num=22, revi=01 → identical result to test 1. Then esh=00, revi=00 → no shift, nerr_o[0]=1.
- Sticky (macro on): mode1, p_reg=74'h1 << 73 | 74'h5 → grd_o[0]=0, stk_o[0]=1. Macro off → both 0.
- Backpressure: stream 4 bundles with out_ready=0 for 3 cycles → in_ready falls after 2 accepts. Bundles emerge in order, each held stable until taken.
- Reset: assert rst with 2 bundles in flight → out_valid=0 and outputs 0 in the same cycle. After release, the first new bundle appears 2 cycles after accept.

Source files
------------

// File: rtl/maf_t5_norm_if.sv
// Bundle interface between T4_3, the normalization stage and the rounder.
// slave: the normalization stage; master: the surrounding pipeline.
interface maf_t5_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic [73:0] p_reg;
  logic [9:0]  sh_num;
  logic [1:0]  esh;
  logic [1:0]  revi;
  logic [11:0] e_in;
  logic        s2;
  logic        s2h;
  logic [2:0]  cont;
  logic        out_valid;
  logic        out_ready;
  logic [52:0] mant_o;
  logic [1:0]  grd_o;
  logic [1:0]  stk_o;
  logic [1:0]  zero_o;
  logic [1:0]  nerr_o;
  logic [11:0] e_o;
  logic        s2_o;
  logic        s2h_o;
  logic [2:0]  cont_o;

  modport slave (
    input  in_valid, p_reg, sh_num, esh, revi, e_in, s2, s2h, cont, out_ready,
    output in_ready, out_valid, mant_o, grd_o, stk_o, zero_o, nerr_o, e_o, s2_o, s2h_o, cont_o
  );

  modport master (
    output in_valid, p_reg, sh_num, esh, revi, e_in, s2, s2h, cont, out_ready,
    input  in_ready, out_valid, mant_o, grd_o, stk_o, zero_o, nerr_o, e_o, s2_o, s2h_o, cont_o
  );
endinterface

// File: rtl/maf_t5_norm.sv
// MAF normalization stage: capture (A) then per-lane left shift (B), valid/ready pipelined.
// Define MAF_NORM_STICKY_EN to build guard/sticky outputs; otherwise they are tied to 0.
module maf_t5_norm (
  input  logic               clk,
  input  logic               rst,
  maf_t5_norm_if.slave       bus_io
);

  logic        va_q, va_d, vb_q, vb_d;
  logic        b_load, a_take;

  logic [73:0] p_a_q;
  logic [9:0]  sh_a_q;
  logic [1:0]  esh_a_q, revi_a_q;
  logic [11:0] e_a_q;
  logic        s2_a_q, s2h_a_q;
  logic [2:0]  cont_a_q;

  logic [52:0] mant_q, mant_d;
  logic [1:0]  grd_q, grd_d, stk_q, stk_d, zero_q, zero_d, nerr_q, nerr_d;
  logic [11:0] e_q;
  logic        s2_q, s2h_q;
  logic [2:0]  cont_q;

  logic        dual;
  logic [6:0]  amt_s;
  logic [5:0]  amt_h, amt_l;
  logic [73:0] sh_s;
  logic [36:0] sh_h, sh_l;

  assign b_load = !vb_q || bus_io.out_ready;
  assign bus_io.in_ready = !va_q || b_load;
  assign a_take = bus_io.in_valid && bus_io.in_ready;

  always_comb begin
    va_d = va_q;
    if (b_load) va_d = 1'b0;
    if (a_take) va_d = 1'b1;
    vb_d = b_load ? va_q : vb_q;
  end

  // Lane shifters; dual lanes are shifted as separate 37-bit words so nothing crosses over.
  always_comb begin
    dual  = !cont_a_q[1] && cont_a_q[0];
    amt_s = {1'b0, (esh_a_q[0] ? sh_a_q[5:0] : 6'd0)} + {6'd0, revi_a_q[0]};
    amt_h = {1'b0, (esh_a_q[1] ? sh_a_q[9:5] : 5'd0)} + {5'd0, revi_a_q[1]};
    amt_l = {1'b0, (esh_a_q[0] ? sh_a_q[4:0] : 5'd0)} + {5'd0, revi_a_q[0]};
    sh_s  = p_a_q << amt_s;
    sh_h  = p_a_q[73:37] << amt_h;
    sh_l  = p_a_q[36:0] << amt_l;

    mant_d = '0;
    zero_d = '0;
    nerr_d = '0;
    grd_d  = '0;
    stk_d  = '0;
    if (dual) begin
      mant_d = {5'd0, sh_h[36:13], sh_l[36:13]};
      zero_d = {~|sh_h, ~|sh_l};
      nerr_d = {(|sh_h) && !sh_h[36], (|sh_l) && !sh_l[36]};
`ifdef MAF_NORM_STICKY_EN
      grd_d  = {sh_h[12], sh_l[12]};
      stk_d  = {|sh_h[11:0], |sh_l[11:0]};
`endif
    end else begin
      mant_d = sh_s[73:21];
      zero_d = {1'b0, ~|sh_s};
      nerr_d = {1'b0, (|sh_s) && !sh_s[73]};
`ifdef MAF_NORM_STICKY_EN
      grd_d  = {1'b0, sh_s[20]};
      stk_d  = {1'b0, |sh_s[19:0]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_a_q    <= '0;
      sh_a_q   <= '0;
      esh_a_q  <= '0;
      revi_a_q <= '0;
      e_a_q    <= '0;
      s2_a_q   <= 1'b0;
      s2h_a_q  <= 1'b0;
      cont_a_q <= '0;
    end else if (a_take) begin
      p_a_q    <= bus_io.p_reg;
      sh_a_q   <= bus_io.sh_num;
      esh_a_q  <= bus_io.esh;
      revi_a_q <= bus_io.revi;
      e_a_q    <= bus_io.e_in;
      s2_a_q   <= bus_io.s2;
      s2h_a_q  <= bus_io.s2h;
      cont_a_q <= bus_io.cont;
    end
  end

  // B data only moves when a real bundle transfers, so outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q <= '0;
      grd_q  <= '0;
      stk_q  <= '0;
      zero_q <= '0;
      nerr_q <= '0;
      e_q    <= '0;
      s2_q   <= 1'b0;
      s2h_q  <= 1'b0;
      cont_q <= '0;
    end else if (b_load && va_q) begin
      mant_q <= mant_d;
      grd_q  <= grd_d;
      stk_q  <= stk_d;
      zero_q <= zero_d;
      nerr_q <= nerr_d;
      e_q    <= e_a_q;
      s2_q   <= s2_a_q;
      s2h_q  <= s2h_a_q;
      cont_q <= cont_a_q;
    end
  end

  assign bus_io.out_valid = vb_q;
  assign bus_io.mant_o    = mant_q;
  assign bus_io.grd_o     = grd_q;
  assign bus_io.stk_o     = stk_q;
  assign bus_io.zero_o    = zero_q;
  assign bus_io.nerr_o    = nerr_q;
  assign bus_io.e_o       = e_q;
  assign bus_io.s2_o      = s2_q;
  assign bus_io.s2h_o     = s2h_q;
  assign bus_io.cont_o    = cont_q;

endmodule

// File: tb/tb_maf_t5_norm.sv
// Directed bench for maf_t5_norm: vector table plus backpressure and reset sequences.
module tb_maf_t5_norm;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  maf_t5_norm_if bus ();

  maf_t5_norm u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [73:0] p;
    logic [9:0]  sh;
    logic [1:0]  esh;
    logic [1:0]  revi;
    logic [2:0]  cont;
    logic [52:0] mant;
    logic [1:0]  grd;
    logic [1:0]  stk;
    logic [1:0]  zero;
    logic [1:0]  nerr;
  } vec_t;

  localparam int NumVec = 11;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic [73:0] p, input logic [9:0] sh, input logic [1:0] esh,
                              input logic [1:0] revi, input logic [2:0] cont,
                              input logic [52:0] mant, input logic [1:0] grd,
                              input logic [1:0] stk, input logic [1:0] zero,
                              input logic [1:0] nerr);
    vec_t v;
    v.p = p; v.sh = sh; v.esh = esh; v.revi = revi; v.cont = cont;
    v.mant = mant; v.grd = grd; v.stk = stk; v.zero = zero; v.nerr = nerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0; bus.p_reg = '0; bus.sh_num = '0; bus.esh = '0; bus.revi = '0;
    bus.e_in = '0; bus.s2 = 1'b0; bus.s2h = 1'b0; bus.cont = '0; bus.out_ready = 1'b1;
  endtask

  task automatic drive_simple(input logic [73:0] p, input logic [11:0] e);
    bus.p_reg = p; bus.sh_num = '0; bus.esh = '0; bus.revi = '0; bus.cont = '0; bus.e_in = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] eg, es;
    logic [11:0] e_exp;
    int sent, rcvd, cyc;
    logic held_v;
    logic [11:0] held_e;
    logic [52:0] held_m;

    checks = 0;
    failures = 0;

    //          p                              sh               esh    revi   cont
    vecs[0]  = mk(74'h1 << 50, 10'd23, 2'b01, 2'b00, 3'b000,
                  53'h1 << 52, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[1]  = mk((74'h1 << 57) | (74'h1 << 30), {5'd16, 5'd6}, 2'b11, 2'b00, 3'b001,
                  53'h8000_0080_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[2]  = mk(74'h1 << 50, 10'd22, 2'b01, 2'b01, 3'b000,
                  53'h1 << 52, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[3]  = mk(74'h1 << 50, 10'd22, 2'b00, 2'b00, 3'b000,
                  53'h2000_0000, 2'b00, 2'b00, 2'b00, 2'b01);
    vecs[4]  = mk((74'h1 << 73) | 74'h5, 10'd0, 2'b00, 2'b00, 3'b000,
                  53'h1 << 52, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[5]  = mk(74'h0, 10'd5, 2'b01, 2'b01, 3'b000,
                  53'h0, 2'b00, 2'b00, 2'b01, 2'b00);
    vecs[6]  = mk(74'h1 << 73, 10'd0, 2'b00, 2'b00, 3'b001,
                  53'h8000_0000_0000, 2'b00, 2'b00, 2'b01, 2'b00);
    vecs[7]  = mk({37'h1F_FFFF_FFFF, 37'h0}, {5'd31, 5'd0}, 2'b10, 2'b10, 3'b001,
                  53'hF800_0000_0000, 2'b00, 2'b00, 2'b01, 2'b00);
    vecs[8]  = mk({37'h1, 37'h10_0000_1001}, 10'd0, 2'b00, 2'b00, 3'b101,
                  53'h80_0000, 2'b01, 2'b11, 2'b00, 2'b10);
    vecs[9]  = mk(74'h1 << 9, 10'd63, 2'b01, 2'b01, 3'b110,
                  53'h1 << 52, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[10] = mk(74'h1 << 10, 10'd63, 2'b01, 2'b01, 3'b010,
                  53'h0, 2'b00, 2'b00, 2'b01, 2'b00);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_mant", bus.mant_o, 53'h0);
    chk("rst_flags", {bus.grd_o, bus.stk_o, bus.zero_o, bus.nerr_o}, 8'h0);
    chk("rst_pass", {bus.e_o, bus.s2_o, bus.s2h_o, bus.cont_o}, 17'h0);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      bus.p_reg = vecs[i].p; bus.sh_num = vecs[i].sh; bus.esh = vecs[i].esh;
      bus.revi = vecs[i].revi; bus.cont = vecs[i].cont;
      e_exp = 12'h100 + 12'(i);
      bus.e_in = e_exp; bus.s2 = i[0]; bus.s2h = i[1];
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_latency", i), bus.out_valid, 1'b0);
      @(negedge clk);
`ifdef MAF_NORM_STICKY_EN
      eg = vecs[i].grd; es = vecs[i].stk;
`else
      eg = 2'b00; es = 2'b00;
`endif
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("v%0d_mant", i), bus.mant_o, vecs[i].mant);
      chk($sformatf("v%0d_grd", i), bus.grd_o, eg);
      chk($sformatf("v%0d_stk", i), bus.stk_o, es);
      chk($sformatf("v%0d_zero", i), bus.zero_o, vecs[i].zero);
      chk($sformatf("v%0d_nerr", i), bus.nerr_o, vecs[i].nerr);
      chk($sformatf("v%0d_pass", i), {bus.e_o, bus.s2_o, bus.s2h_o, bus.cont_o},
          {e_exp, i[0], i[1], vecs[i].cont});
    end

    // Backpressure: out_ready low for the first 3 cycles while 4 bundles stream in.
    sent = 0; rcvd = 0; cyc = 0; held_v = 1'b0; held_e = '0; held_m = '0;
    @(negedge clk);
    while (rcvd < 4 && cyc < 40) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 3);
      bus.in_valid = (sent < 4);
      if (sent < 4) drive_simple(74'(sent + 1) << 21, 12'h200 + 12'(sent));
      #1;
      if (held_v) begin
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        chk("bp_hold_e", bus.e_o, held_e);
        chk("bp_hold_mant", bus.mant_o, held_m);
      end
      if (cyc == 2) begin
        chk("bp_sent_before_stall", sent, 2);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_order_e%0d", rcvd), bus.e_o, 12'h200 + 12'(rcvd));
        chk($sformatf("bp_order_m%0d", rcvd), bus.mant_o, 53'(rcvd + 1));
        rcvd++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_e = bus.e_o;
      held_m = bus.mant_o;
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_rcvd", rcvd, 4);
    repeat (2) @(negedge clk);
    chk("bp_drained", bus.out_valid, 1'b0);

    // Reset with two bundles in flight, then a fresh bundle afterwards.
    bus.out_ready = 1'b0;
    drive_simple(74'h3 << 21, 12'h300);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive_simple(74'h4 << 21, 12'h301);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_full_valid", bus.out_valid, 1'b1);
    chk("rst2_full_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst2_out_valid", bus.out_valid, 1'b0);
    chk("rst2_in_ready", bus.in_ready, 1'b1);
    chk("rst2_mant", bus.mant_o, 53'h0);
    chk("rst2_e", bus.e_o, 12'h0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive_simple(74'h7 << 21, 12'h3A5);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst2_new_latency", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("rst2_new_valid", bus.out_valid, 1'b1);
    chk("rst2_new_e", bus.e_o, 12'h3A5);
    chk("rst2_new_mant", bus.mant_o, 53'h7);
    @(negedge clk);
    chk("rst2_no_dup", bus.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
